hazard_scoreboard_unit: RTL and testbench

//  Parametrised successor hazard unit for the 5-stage MIPS pipeline. Keeps load-use, branch and syscall

---
 rtl/hazard_scoreboard_unit.sv | 187 ++++++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline.
// Covers load-use, branch and syscall stalls, M/W forwarding, and a scoreboard
// that tracks fixed-latency long ops writing straight into the register file.
module hazard_scoreboard_unit #(
    parameter int unsigned LONG_SLOTS = 2,
    parameter int unsigned LONG_LAT   = 8,
    parameter int unsigned CNT_W      = 16,
    parameter logic [4:0]  REG_V0     = 5'd2,
    parameter logic [4:0]  REG_A0     = 5'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       WriteRegD,
    input  logic             BranchD,
    input  logic             syscallD,
    input  logic             LongOpD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic             MemtoRegE,
    input  logic             RegWriteE,
    input  logic [4:0]       WriteRegM,
    input  logic             MemtoRegM,
    input  logic             RegWriteM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             long_wb_valid,
    output logic [4:0]       long_wb_reg,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned   CW       = $clog2(LONG_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(LONG_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRAIN   = 2'd1,
        S_RELEASE = 2'd2
    } sys_state_t;

    sys_state_t r_state;
    sys_state_t w_state_nxt;

    logic [LONG_SLOTS-1:0] r_valid;
    logic [4:0]            r_dest [LONG_SLOTS];
    logic [CW-1:0]         r_cnt  [LONG_SLOTS];
    logic                  r_wb_valid;
    logic [4:0]            r_wb_reg;
    logic [CNT_W-1:0]      r_stall_cycles;

    logic                  w_lw, w_br, w_sb, w_full, w_sys, w_hold;
    logic                  w_pending;
    logic                  w_alloc;
    logic [LONG_SLOTS-1:0] w_alloc_oh;

    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic is_arg(input logic [4:0] r);
        return (r == REG_V0) || (r == REG_A0);
    endfunction

    // Stall terms, syscall pending detection and free-slot selection.
    always_comb begin
        w_lw = MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
        w_br = BranchD &&
               ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
        w_sb      = 1'b0;
        w_pending = (RegWriteE && is_arg(WriteRegE)) ||
                    (RegWriteM && is_arg(WriteRegM)) ||
                    (RegWriteW && is_arg(WriteRegW));
        for (int unsigned i = 0; i < LONG_SLOTS; i++) begin
            if (r_valid[i]) begin
                if (hit(r_dest[i], RsD) || hit(r_dest[i], RtD) || hit(r_dest[i], WriteRegD))
                    w_sb = 1'b1;
                if (is_arg(r_dest[i]))
                    w_pending = 1'b1;
            end
        end
        w_full  = LongOpD && (&r_valid);
        w_sys   = (r_state == S_DRAIN);
        w_hold  = w_lw || w_br || w_sb || w_full || w_sys;
        w_alloc = LongOpD && !w_hold;
        w_alloc_oh = '0;
        for (int unsigned i = 0; i < LONG_SLOTS; i++) begin
            if (!r_valid[i] && (w_alloc_oh == '0))
                w_alloc_oh[i] = 1'b1;
        end
    end

    // Pipeline control and forwarding outputs, forced safe while in reset.
    always_comb begin
        StallF    = !w_hold;
        StallD    = !w_hold;
        FlushE    = w_hold;
        ForwardAD = RegWriteM && hit(RsD, WriteRegM);
        ForwardBD = RegWriteM && hit(RtD, WriteRegM);
        ForwardAE = (RegWriteM && hit(RsE, WriteRegM)) ? 2'b10 :
                    (RegWriteW && hit(RsE, WriteRegW)) ? 2'b01 : 2'b00;
        ForwardBE = (RegWriteM && hit(RtE, WriteRegM)) ? 2'b10 :
                    (RegWriteW && hit(RtE, WriteRegW)) ? 2'b01 : 2'b00;
        if (rst) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushE    = 1'b1;
            ForwardAD = 1'b0;
            ForwardBD = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    // Syscall FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Syscall FSM next state: drain pending v0/a0 writers before the syscall advances.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (syscallD && w_pending) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (!syscallD)             w_state_nxt = S_IDLE;
                       else if (!w_pending)       w_state_nxt = S_RELEASE;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Scoreboard slots and retirement pulse.
    // The pulse is registered off cnt==1 so it is high in the slot's final
    // valid cycle (cnt==0), i.e. LONG_LAT cycles after issue; the slot clears
    // at the end of that cycle, so dependents advance the cycle after the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            for (int unsigned i = 0; i < LONG_SLOTS; i++) begin
                r_dest[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            for (int unsigned i = 0; i < LONG_SLOTS; i++) begin
                if (r_valid[i]) begin
                    if (r_cnt[i] == '0) r_valid[i] <= 1'b0;
                    else                r_cnt[i]   <= r_cnt[i] - CNT_ONE;
                    if (r_cnt[i] == CNT_ONE) begin
                        r_wb_valid <= 1'b1;
                        r_wb_reg   <= r_dest[i];
                    end
                end else if (w_alloc && w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_dest[i]  <= WriteRegD;
                    r_cnt[i]   <= CNT_INIT;
                end
            end
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  r_stall_cycles <= '0;
        else if (w_hold && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    assign long_wb_valid = r_wb_valid;
    assign long_wb_reg   = r_wb_reg;
    assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with a long-op retirement scoreboard.
module tb_hazard_scoreboard_unit;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic             BranchD, syscallD, LongOpD, MemtoRegE, RegWriteE;
    logic             MemtoRegM, RegWriteM, RegWriteW;
    logic             StallF, StallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             long_wb_valid;
    logic [4:0]       long_wb_reg;
    logic [CNT_W-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [4:0] rg;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    hazard_scoreboard_unit #(
        .LONG_SLOTS(2),
        .LONG_LAT  (8),
        .CNT_W     (CNT_W),
        .REG_V0    (5'd2),
        .REG_A0    (5'd4)
    ) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .WriteRegD(WriteRegD),
        .BranchD(BranchD), .syscallD(syscallD), .LongOpD(LongOpD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .long_wb_valid(long_wb_valid), .long_wb_reg(long_wb_reg),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        RsD = '0; RtD = '0; WriteRegD = '0; BranchD = 0; syscallD = 0; LongOpD = 0;
        RsE = '0; RtE = '0; WriteRegE = '0; MemtoRegE = 0; RegWriteE = 0;
        WriteRegM = '0; MemtoRegM = 0; RegWriteM = 0; WriteRegW = '0; RegWriteW = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // Retirement scoreboard: a pulse is expected exactly at the due cycle of the queue head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("wb_valid", long_wb_valid, 1);
                check("wb_reg", long_wb_reg, exp_q[0].rg);
                void'(exp_q.pop_front());
            end else begin
                check("wb_idle", long_wb_valid, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, adv;
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        smp();
        check("rst_StallF", StallF, 0);
        check("rst_StallD", StallD, 0);
        check("rst_FlushE", FlushE, 1);
        check("rst_FwdAE", ForwardAE, 0);
        check("rst_wb", long_wb_valid, 0);
        check("rst_wbreg", long_wb_reg, 0);
        check("rst_cnt", stall_cycles, 0);
        nxt();
        rst = 1'b0;
        mon_en = 1'b1;

        // load-use
        RsD = 5'd8; MemtoRegE = 1; RtE = 5'd8; RegWriteE = 1; WriteRegE = 5'd8;
        smp();
        check("lw_StallD", StallD, 0);
        check("lw_StallF", StallF, 0);
        check("lw_FlushE", FlushE, 1);
        nxt();
        clr(); RsE = 5'd8; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd8;
        smp();
        check("lw_after_StallD", StallD, 1);
        check("lw_after_FlushE", FlushE, 0);
        check("lw_FwdAE_M", ForwardAE, 2'b10);
        nxt();

        // forwarding sources and priority
        clr(); RsE = 5'd8; RtE = 5'd9; RegWriteW = 1; WriteRegW = 5'd8; RegWriteM = 1; WriteRegM = 5'd9;
        smp();
        check("fwd_AE_W", ForwardAE, 2'b01);
        check("fwd_BE_M", ForwardBE, 2'b10);
        nxt();
        clr(); RsE = 5'd8; RegWriteM = 1; WriteRegM = 5'd8; RegWriteW = 1; WriteRegW = 5'd8;
        smp();
        check("fwd_AE_prio", ForwardAE, 2'b10);
        check("fwd_BE_none", ForwardBE, 2'b00);
        nxt();
        clr(); RegWriteM = 1; RegWriteW = 1;
        smp();
        check("fwd_r0_AE", ForwardAE, 2'b00);
        check("fwd_r0_AD", ForwardAD, 0);
        nxt();

        // branch hazards
        clr(); BranchD = 1; RsD = 5'd5; RegWriteE = 1; WriteRegE = 5'd5;
        smp();
        check("br_E_StallD", StallD, 0);
        check("br_E_FwdAD", ForwardAD, 0);
        nxt();
        clr(); BranchD = 1; RsD = 5'd5; RegWriteM = 1; WriteRegM = 5'd5;
        smp();
        check("br_M_StallD", StallD, 1);
        check("br_M_FwdAD", ForwardAD, 1);
        check("br_M_FwdBD", ForwardBD, 0);
        nxt();
        clr(); BranchD = 1; RtD = 5'd6; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5'd6;
        smp();
        check("br_ld_StallD", StallD, 0);
        check("br_ld_FwdBD", ForwardBD, 1);
        nxt();
        clr();
        smp();
        check("cnt_3", stall_cycles, 3);
        nxt();

        // long op RAW
        LongOpD = 1; WriteRegD = 5'd9;
        smp();
        check("lo_issue", StallD, 1);
        k0 = cyc;
        exp_q.push_back('{rg: 5'd9, due: k0 + 8});
        nxt();
        clr(); RsD = 5'd9;
        adv = -1;
        for (int n = 0; n < 20; n++) begin
            smp();
            if (StallD === 1'b1) begin
                adv = cyc;
                break;
            end
            nxt();
        end
        check("lo_raw_adv", adv, k0 + 9);
        nxt();
        clr();
        smp();
        check("cnt_11", stall_cycles, 11);
        nxt();

        // slots full
        LongOpD = 1; WriteRegD = 5'd10;
        smp();
        check("full_1", StallD, 1);
        k0 = cyc;
        exp_q.push_back('{rg: 5'd10, due: cyc + 8});
        nxt();
        WriteRegD = 5'd11;
        smp();
        check("full_2", StallD, 1);
        exp_q.push_back('{rg: 5'd11, due: cyc + 8});
        nxt();
        WriteRegD = 5'd12;
        adv = -1;
        for (int n = 0; n < 20; n++) begin
            smp();
            if (StallD === 1'b1) begin
                adv = cyc;
                exp_q.push_back('{rg: 5'd12, due: cyc + 8});
                break;
            end
            nxt();
        end
        check("full_3_adv", adv, k0 + 9);
        nxt();
        clr();
        for (int n = 0; n < 30; n++) begin
            smp();
            if (exp_q.size() == 0) break;
            nxt();
        end
        check("q_drain", exp_q.size(), 0);
        nxt();

        // syscall drain
        syscallD = 1; RegWriteM = 1; WriteRegM = 5'd2;
        smp();
        nxt();
        clr(); syscallD = 1;
        smp();
        check("sys_drain_StallD", StallD, 0);
        check("sys_drain_FlushE", FlushE, 1);
        nxt();
        smp();
        check("sys_release", StallD, 1);
        nxt();
        clr();
        smp();
        check("sys_idle", StallD, 1);
        nxt();
        syscallD = 1;
        smp();
        check("sys_free_1", StallD, 1);
        nxt();
        smp();
        check("sys_free_2", StallD, 1);
        nxt();
        clr(); syscallD = 1; RegWriteE = 1; WriteRegE = 5'd4;
        smp();
        nxt();
        smp();
        check("sys_a0_drain", StallD, 0);
        nxt();
        clr();
        smp();
        check("sys_flush_last", StallD, 0);
        nxt();
        smp();
        check("sys_flush_idle", StallD, 1);
        nxt();

        // reset with in-flight slots
        LongOpD = 1; WriteRegD = 5'd13;
        smp();
        check("rs_issue1", StallD, 1);
        nxt();
        WriteRegD = 5'd14;
        smp();
        check("rs_issue2", StallD, 1);
        nxt();
        clr();
        nxt();
        nxt();
        mon_en = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        RsE = 5'd8; RegWriteM = 1; WriteRegM = 5'd8;
        smp();
        check("rs_StallD", StallD, 0);
        check("rs_StallF", StallF, 0);
        check("rs_FlushE", FlushE, 1);
        check("rs_FwdAE", ForwardAE, 2'b00);
        check("rs_wb", long_wb_valid, 0);
        check("rs_cnt", stall_cycles, 0);
        nxt();
        rst = 1'b0;
        mon_en = 1'b1;
        clr(); RsD = 5'd13; RtD = 5'd14;
        smp();
        check("rs_slots_clear", StallD, 1);
        nxt();
        clr();
        repeat (12) nxt();

        // saturating stall counter
        MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
        repeat (5) nxt();
        clr();
        smp();
        check("cnt_5", stall_cycles, 5);
        nxt();
        MemtoRegE = 1; RtE = 5'd8; RsD = 5'd8;
        repeat (15) nxt();
        clr();
        smp();
        check("cnt_sat", stall_cycles, 15);
        nxt();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
